// File: rtl/reg_seq_driver_pkg.sv
// Shared encodings for reg_seq_driver: register FunSel codes, request op codes,
// sequencer states and the first-register-cycle decode.
package reg_seq_driver_pkg;

  localparam logic [2:0] FS_DEC        = 3'b000;
  localparam logic [2:0] FS_INC        = 3'b001;
  localparam logic [2:0] FS_LOAD       = 3'b010;
  localparam logic [2:0] FS_CLR        = 3'b011;
  localparam logic [2:0] FS_LDLO_CLRHI = 3'b100;
  localparam logic [2:0] FS_WRLO       = 3'b101;
  localparam logic [2:0] FS_WRHI       = 3'b110;
  localparam logic [2:0] FS_LDSX       = 3'b111;

  localparam logic [2:0] OP_CLEAR  = 3'b000;
  localparam logic [2:0] OP_LOAD16 = 3'b001;
  localparam logic [2:0] OP_LOADZ8 = 3'b010;
  localparam logic [2:0] OP_LOADS8 = 3'b011;
  localparam logic [2:0] OP_WRLO   = 3'b100;
  localparam logic [2:0] OP_WRHI   = 3'b101;
  localparam logic [2:0] OP_INCN   = 3'b110;
  localparam logic [2:0] OP_DECN   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_ISSUE_HI = 3'd2,
    ST_STEP     = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0] fs;
    logic [7:0] i;
  } reg_cyc_t;

  function automatic logic is_count_op(input logic [2:0] op);
    return (op == OP_INCN) || (op == OP_DECN);
  endfunction

  // FunSel/I for the first E cycle of an op; LOAD16's high-byte cycle is issued from ISSUE.
  function automatic reg_cyc_t first_cycle(input logic [2:0] op, input logic [15:0] data);
    reg_cyc_t c;
    c.i = 8'h00;
    case (op)
      OP_CLEAR:  c.fs = FS_CLR;
      OP_LOAD16: begin c.fs = FS_LDLO_CLRHI; c.i = data[7:0];  end
      OP_LOADZ8: begin c.fs = FS_LDLO_CLRHI; c.i = data[7:0];  end
      OP_LOADS8: begin c.fs = FS_LDSX;       c.i = data[7:0];  end
      OP_WRLO:   begin c.fs = FS_WRLO;       c.i = data[7:0];  end
      OP_WRHI:   begin c.fs = FS_WRHI;       c.i = data[15:8]; end
      OP_INCN:   c.fs = FS_INC;
      default:   c.fs = FS_DEC;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/reg_seq_driver.sv
// Expands high-level register requests into FunSel/E/I cycles for a 16-bit register.
// Handshake: a request is accepted on a rising edge where ReqValid && ReqReady; ReqReady is high only in IDLE.
module reg_seq_driver
  import reg_seq_driver_pkg::*;
#(
  parameter int n  = 16,
  parameter int CW = 8
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          ReqValid,
  output logic          ReqReady,
  input  logic [2:0]    ReqOp,
  input  logic [n-1:0]  ReqData,
  input  logic [CW-1:0] ReqCount,
  output logic [2:0]    FunSel,
  output logic          E,
  output logic [7:0]    I,
  output logic          Done,
  output logic          Busy,
  output state_t        DbgState
);

  state_t        r_state;
  logic [2:0]    r_op;
  logic [15:0]   r_data;
  logic [CW-1:0] r_rem;
  logic [2:0]    r_fs;
  logic          r_e;
  logic [7:0]    r_i;
  logic          r_done;

  state_t        w_nxt_state;
  logic [2:0]    w_nxt_fs;
  logic          w_nxt_e;
  logic [7:0]    w_nxt_i;
  logic          w_nxt_done;
  logic          w_accept;
  logic          w_more_steps;
  logic [2:0]    w_step_fs;
  reg_cyc_t      w_first;

  assign w_accept     = ReqValid && (r_state == ST_IDLE);
  assign w_first      = first_cycle(ReqOp, ReqData[15:0]);
  assign w_more_steps = is_count_op(r_op) && (r_rem > CW'(1));
  assign w_step_fs    = (r_op == OP_INCN) ? FS_INC : FS_DEC;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_fs    <= FS_DEC;
      r_e     <= 1'b0;
      r_i     <= 8'h00;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_fs    <= w_nxt_fs;
      r_e     <= w_nxt_e;
      r_i     <= w_nxt_i;
      r_done  <= w_nxt_done;
    end
  end

  // Request fields are captured at accept so the requester may change them while Busy.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_op   <= OP_CLEAR;
      r_data <= 16'h0000;
      r_rem  <= '0;
    end else if (w_accept) begin
      r_op   <= ReqOp;
      r_data <= ReqData[15:0];
      r_rem  <= ReqCount;
    end else if ((r_state == ST_ISSUE) || (r_state == ST_STEP)) begin
      r_rem  <= r_rem - CW'(1);
    end
  end

  // Next-state and next-output decode; outputs are registered so E cycles start in T1.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_fs    = FS_DEC;
    w_nxt_e     = 1'b0;
    w_nxt_i     = 8'h00;
    w_nxt_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ReqValid) begin
          if (is_count_op(ReqOp) && (ReqCount == '0)) begin
            w_nxt_state = ST_DONE;
            w_nxt_done  = 1'b1;
          end else begin
            w_nxt_state = ST_ISSUE;
            w_nxt_e     = 1'b1;
            w_nxt_fs    = w_first.fs;
            w_nxt_i     = w_first.i;
          end
        end
      end
      ST_ISSUE: begin
        if (r_op == OP_LOAD16) begin
          w_nxt_state = ST_ISSUE_HI;
          w_nxt_e     = 1'b1;
          w_nxt_fs    = FS_WRHI;
          w_nxt_i     = r_data[15:8];
        end else if (w_more_steps) begin
          w_nxt_state = ST_STEP;
          w_nxt_e     = 1'b1;
          w_nxt_fs    = w_step_fs;
        end else begin
          w_nxt_state = ST_DONE;
          w_nxt_done  = 1'b1;
        end
      end
      ST_ISSUE_HI: begin
        w_nxt_state = ST_DONE;
        w_nxt_done  = 1'b1;
      end
      ST_STEP: begin
        if (w_more_steps) begin
          w_nxt_e  = 1'b1;
          w_nxt_fs = w_step_fs;
        end else begin
          w_nxt_state = ST_DONE;
          w_nxt_done  = 1'b1;
        end
      end
      ST_DONE: w_nxt_state = ST_IDLE;
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  assign ReqReady = (r_state == ST_IDLE);
  assign Busy     = (r_state != ST_IDLE);
  assign FunSel   = r_fs;
  assign E        = r_e;
  assign I        = r_i;
  assign Done     = r_done;
  assign DbgState = r_state;

endmodule

// File: tb/tb_reg_seq_driver.sv
// Bench for reg_seq_driver: drives ops against a behavioural 16-bit register model
// and checks cycle-level FunSel/E/I, Done latency and the register value at Done.
module tb_reg_seq_driver;
  import reg_seq_driver_pkg::*;

  logic        Clock;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic [2:0]  ReqOp;
  logic [15:0] ReqData;
  logic [7:0]  ReqCount;
  logic [2:0]  FunSel;
  logic        E;
  logic [7:0]  I;
  logic        Done;
  logic        Busy;
  state_t      DbgState;

  int total = 0;
  int bad   = 0;
  logic [15:0] q_model = 16'h0000;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [15:0] data;
    logic [7:0]  cnt;
    logic [15:0] q;
    int          k;
  } vec_t;
  vec_t tv[13];

  reg_seq_driver #(.n(16), .CW(8)) dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqOp(ReqOp), .ReqData(ReqData), .ReqCount(ReqCount), .FunSel(FunSel),
    .E(E), .I(I), .Done(Done), .Busy(Busy), .DbgState(DbgState)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural register: samples FunSel/I at each rising edge with E=1.
  always @(posedge Clock) begin
    if (E) begin
      case (FunSel)
        3'b000: q_model <= q_model - 16'd1;
        3'b001: q_model <= q_model + 16'd1;
        3'b010: q_model <= {8'h00, I};
        3'b011: q_model <= 16'h0000;
        3'b100: q_model <= {8'h00, I};
        3'b101: q_model <= {q_model[15:8], I};
        3'b110: q_model <= {I, q_model[7:0]};
        default: q_model <= {{8{I[7]}}, I};
      endcase
    end
  end

  // Scoreboard consumer plus idle-lane check.
  always @(negedge Clock) begin
    if (!E) begin
      chk("idle_funsel", {29'd0, FunSel}, 32'd0);
      chk("idle_i", {24'd0, I}, 32'd0);
    end
    if (Done) begin
      if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else chk("q_at_done", {16'd0, q_model}, {16'd0, exp_q.pop_front()});
    end
  end

  function automatic logic [10:0] exp_cycle(input logic [2:0] op, input logic [15:0] d, input int j);
    case (op)
      3'b000: return {3'b011, 8'h00};
      3'b001: return (j == 1) ? {3'b100, d[7:0]} : {3'b110, d[15:8]};
      3'b010: return {3'b100, d[7:0]};
      3'b011: return {3'b111, d[7:0]};
      3'b100: return {3'b101, d[7:0]};
      3'b101: return {3'b110, d[15:8]};
      3'b110: return {3'b001, 8'h00};
      default: return {3'b000, 8'h00};
    endcase
  endfunction

  // Entered and left at a falling edge.
  task automatic do_op(input logic [2:0] op, input logic [15:0] data, input logic [7:0] cnt,
                       input logic [15:0] q, input int k);
    int w;
    int j;
    logic [10:0] ec;
    w = 0;
    while (!ReqReady && w < 50) begin @(negedge Clock); w++; end
    chk("ready_timeout", {31'd0, ReqReady}, 32'd1);
    ReqOp = op; ReqData = data; ReqCount = cnt; ReqValid = 1'b1;
    exp_q.push_back(q);
    @(posedge Clock);
    @(negedge Clock);
    ReqValid = 1'b0;
    ReqOp = 3'($urandom_range(0, 7));
    ReqData = 16'($urandom);
    ReqCount = 8'($urandom_range(0, 255));
    chk("busy_t1", {31'd0, Busy}, 32'd1);
    j = 1;
    while (!Done && j <= 300) begin
      ec = exp_cycle(op, data, j);
      chk("e_cycle", {31'd0, E}, 32'd1);
      chk("funsel_cycle", {29'd0, FunSel}, {29'd0, ec[10:8]});
      chk("i_cycle", {24'd0, I}, {24'd0, ec[7:0]});
      @(negedge Clock);
      j++;
    end
    chk("done_seen", {31'd0, Done}, 32'd1);
    chk("done_latency", j, k + 1);
    chk("ready_in_done", {31'd0, ReqReady}, 32'd0);
    chk("e_in_done", {31'd0, E}, 32'd0);
    @(negedge Clock);
    chk("done_pulse", {31'd0, Done}, 32'd0);
    chk("ready_after", {31'd0, ReqReady}, 32'd1);
  endtask

  initial begin
    tv[0]  = '{OP_LOAD16, 16'hA5C3, 8'd0, 16'hA5C3, 2};
    tv[1]  = '{OP_LOADS8, 16'h0080, 8'd0, 16'hFF80, 1};
    tv[2]  = '{OP_WRHI,   16'h1200, 8'd0, 16'h1280, 1};
    tv[3]  = '{OP_LOAD16, 16'hFFFE, 8'd0, 16'hFFFE, 2};
    tv[4]  = '{OP_INCN,   16'h0000, 8'd3, 16'h0001, 3};
    tv[5]  = '{OP_DECN,   16'h0000, 8'd2, 16'hFFFF, 2};
    tv[6]  = '{OP_CLEAR,  16'h7777, 8'd5, 16'h0000, 1};
    tv[7]  = '{OP_LOADZ8, 16'h12F7, 8'd0, 16'h00F7, 1};
    tv[8]  = '{OP_WRLO,   16'h3C55, 8'd0, 16'h0055, 1};
    tv[9]  = '{OP_WRHI,   16'h9A00, 8'd0, 16'h9A55, 1};
    tv[10] = '{OP_DECN,   16'h0000, 8'd0, 16'h9A55, 0};
    tv[11] = '{OP_INCN,   16'h0000, 8'd1, 16'h9A56, 1};
    tv[12] = '{OP_LOADS8, 16'h0042, 8'd0, 16'h0042, 1};

    ReqValid = 1'b0; ReqOp = 3'd0; ReqData = 16'h0; ReqCount = 8'd0;
    Reset = 1'b1;
    #1 Reset = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    chk("rst_e", {31'd0, E}, 32'd0);
    chk("rst_funsel", {29'd0, FunSel}, 32'd0);
    chk("rst_i", {24'd0, I}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_ready", {31'd0, ReqReady}, 32'd1);
    chk("rst_state", {29'd0, DbgState}, {29'd0, ST_IDLE});
    chk("rst_q", {16'd0, q_model}, 32'd0);

    for (int v = 0; v < 13; v++) do_op(tv[v].op, tv[v].data, tv[v].cnt, tv[v].q, tv[v].k);

    // Count-0 DECN with ReqValid held: one accept per IDLE cycle.
    ReqOp = OP_DECN; ReqCount = 8'd0; ReqData = 16'h0; ReqValid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (ReqReady) exp_q.push_back(16'h0042);
      @(posedge Clock);
      @(negedge Clock);
      chk("hold_done", {31'd0, Done}, {31'd0, (c % 2 == 0)});
      chk("hold_ready", {31'd0, ReqReady}, {31'd0, (c % 2 == 1)});
      chk("hold_e", {31'd0, E}, 32'd0);
    end
    ReqValid = 1'b0;
    @(negedge Clock);

    // Reset during the high-byte cycle of LOAD16 abandons the sequence.
    do_op(OP_CLEAR, 16'h0, 8'd0, 16'h0000, 1);
    ReqOp = OP_LOAD16; ReqData = 16'hBEEF; ReqValid = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    ReqValid = 1'b0;
    chk("abort_t1_e", {31'd0, E}, 32'd1);
    @(posedge Clock);
    #2 Reset = 1'b0;
    #1;
    chk("abort_e_async", {31'd0, E}, 32'd0);
    chk("abort_funsel", {29'd0, FunSel}, 32'd0);
    chk("abort_done", {31'd0, Done}, 32'd0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    chk("abort_q", {16'd0, q_model}, 32'h00EF);
    chk("abort_ready", {31'd0, ReqReady}, 32'd1);
    chk("abort_busy", {31'd0, Busy}, 32'd0);

    do_op(OP_LOAD16, 16'hBEEF, 8'd0, 16'hBEEF, 2);
    repeat (2) @(negedge Clock);
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
